// File: rtl/lsq_inorder.sv
// rtl/lsq_inorder.sv - in-order load/store queue feeding a single-request data-memory port
//
// Purpose:
//   Circular queue of memory ops between dispatch and the dmem port. Loads at
//   the head issue once their operands are ready. Stores at the head also wait
//   until they are the ROB head. At most one request is outstanding at a time.
//   A flush during an outstanding request waits for that response and drops it.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         pipeline flush; clears all entries
//   enq_valid / enq_ready         dispatch handshake (ready = count < DEPTH)
//   enq_is_store, enq_funct3,
//   enq_imm, enq_rob, enq_rd_paddr,
//   enq_rs1_paddr, enq_rs2_paddr  fields of the offered entry
//   rs1_paddr, rs2_paddr          head entry sources (0 when empty)
//   p1_data, p2_data, opnd_ready  PRF read of the head sources
//   rob_head                      current ROB head index
//   dmem_addr/rmask/wmask/wdata   registered memory request
//   dmem_resp, dmem_rdata         one-cycle response with the whole line
//   cdb_*                         completion broadcast
//   count                         occupancy
module lsq_inorder #(
  parameter int DEPTH     = 8,
  parameter int P_WIDTH   = 6,
  parameter int ROB_WIDTH = 5,
  parameter int LINE_BITS = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic                       enq_is_store,
  input  logic [2:0]                 enq_funct3,
  input  logic [31:0]                enq_imm,
  input  logic [ROB_WIDTH-1:0]       enq_rob,
  input  logic [P_WIDTH-1:0]         enq_rd_paddr,
  input  logic [P_WIDTH-1:0]         enq_rs1_paddr,
  input  logic [P_WIDTH-1:0]         enq_rs2_paddr,
  output logic [P_WIDTH-1:0]         rs1_paddr,
  output logic [P_WIDTH-1:0]         rs2_paddr,
  input  logic [31:0]                p1_data,
  input  logic [31:0]                p2_data,
  input  logic                       opnd_ready,
  input  logic [ROB_WIDTH-1:0]       rob_head,
  output logic [31:0]                dmem_addr,
  output logic [3:0]                 dmem_rmask,
  output logic [3:0]                 dmem_wmask,
  output logic [31:0]                dmem_wdata,
  input  logic                       dmem_resp,
  input  logic [LINE_BITS-1:0]       dmem_rdata,
  output logic                       cdb_valid,
  output logic                       cdb_is_store,
  output logic [ROB_WIDTH-1:0]       cdb_rob,
  output logic [P_WIDTH-1:0]         cdb_rd_paddr,
  output logic [31:0]                cdb_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int WORDS = LINE_BITS / 32;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_n;

  // Queue storage
  logic                 q_is_store [DEPTH];
  logic [2:0]           q_funct3   [DEPTH];
  logic [31:0]          q_imm      [DEPTH];
  logic [ROB_WIDTH-1:0] q_rob      [DEPTH];
  logic [P_WIDTH-1:0]   q_rd       [DEPTH];
  logic [P_WIDTH-1:0]   q_rs1      [DEPTH];
  logic [P_WIDTH-1:0]   q_rs2      [DEPTH];

  logic [PW-1:0] head_ptr, tail_ptr;

  logic empty;
  logic enq_fire;
  logic issue;
  logic deq;
  logic clr_req;

  // Head entry view
  logic                 h_is_store;
  logic [2:0]           h_funct3;
  logic [31:0]          h_imm;
  logic [ROB_WIDTH-1:0] h_rob;
  logic [P_WIDTH-1:0]   h_rd;

  assign h_is_store = q_is_store[head_ptr];
  assign h_funct3   = q_funct3[head_ptr];
  assign h_imm      = q_imm[head_ptr];
  assign h_rob      = q_rob[head_ptr];
  assign h_rd       = q_rd[head_ptr];

  assign empty     = (count == '0);
  // Based on the registered count only, so a same-cycle dequeue never opens a slot.
  assign enq_ready = (count < CW'(DEPTH));
  assign enq_fire  = enq_valid && enq_ready && !flush;

  assign rs1_paddr = empty ? '0 : q_rs1[head_ptr];
  assign rs2_paddr = empty ? '0 : q_rs2[head_ptr];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (issue) state_n = S_BUSY;
      // A response arriving with the flush closes the request outright.
      S_BUSY:  if (dmem_resp) state_n = S_IDLE;
               else if (flush) state_n = S_DRAIN;
      S_DRAIN: if (dmem_resp) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    issue     = 1'b0;
    deq       = 1'b0;
    clr_req   = 1'b0;
    cdb_valid = 1'b0;
    case (state)
      S_IDLE: begin
        issue = !empty && opnd_ready && !flush &&
                (!h_is_store || (h_rob == rob_head));
      end
      S_BUSY: begin
        if (dmem_resp) begin
          clr_req = 1'b1;
          // The flushed head must not complete even if its response lands now.
          if (!flush) begin
            cdb_valid = 1'b1;
            deq       = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        clr_req = dmem_resp;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- queue
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_is_store[i] <= 1'b0;
        q_funct3[i]   <= '0;
        q_imm[i]      <= '0;
        q_rob[i]      <= '0;
        q_rd[i]       <= '0;
        q_rs1[i]      <= '0;
        q_rs2[i]      <= '0;
      end
    end else begin
      if (enq_fire) begin
        q_is_store[tail_ptr] <= enq_is_store;
        q_funct3[tail_ptr]   <= enq_funct3;
        q_imm[tail_ptr]      <= enq_imm;
        q_rob[tail_ptr]      <= enq_rob;
        q_rd[tail_ptr]       <= enq_rd_paddr;
        q_rs1[tail_ptr]      <= enq_rs1_paddr;
        q_rs2[tail_ptr]      <= enq_rs2_paddr;
        tail_ptr             <= tail_ptr + PW'(1);
      end
      if (deq) head_ptr <= head_ptr + PW'(1);
      case ({enq_fire, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- request build
  logic [31:0]      ea;
  logic [3:0]       base_mask;
  logic [3:0]       mask_n;
  logic [31:0]      wdata_n;
  logic [IDX_W-1:0] widx_n;

  assign ea = p1_data + h_imm;

  always_comb begin
    case (h_funct3[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    // Misaligned accesses simply lose the bytes shifted past bit 3.
    mask_n = base_mask << ea[1:0];

    case (h_funct3[1:0])
      2'b00:   wdata_n = {24'h0, p2_data[7:0]} << {ea[1:0], 3'b000};
      2'b01:   wdata_n = ea[1] ? {p2_data[15:0], 16'h0} : {16'h0, p2_data[15:0]};
      default: wdata_n = p2_data;
    endcase

    widx_n = IDX_W'(ea[31:2] & 30'(WORDS - 1));
  end

  logic [1:0]       ea_lo_q;
  logic [IDX_W-1:0] widx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_addr  <= '0;
      dmem_rmask <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
      ea_lo_q    <= '0;
      widx_q     <= '0;
    end else if (issue) begin
      dmem_addr <= {ea[31:2], 2'b00};
      ea_lo_q   <= ea[1:0];
      widx_q    <= widx_n;
      if (h_is_store) begin
        dmem_rmask <= 4'b0000;
        dmem_wmask <= mask_n;
        dmem_wdata <= wdata_n;
      end else begin
        dmem_rmask <= mask_n;
        dmem_wmask <= 4'b0000;
        dmem_wdata <= '0;
      end
    end else if (clr_req) begin
      dmem_rmask <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
    end
  end

  // ---------------------------------------------------------------- load result
  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val;

  always_comb begin
    rword = dmem_rdata[31:0];
    for (int i = 0; i < WORDS; i++) begin
      if (widx_q == IDX_W'(i)) rword = dmem_rdata[i*32 +: 32];
    end
    case (ea_lo_q)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = ea_lo_q[1] ? rword[31:16] : rword[15:0];
    case (h_funct3)
      3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_val = {24'h0, rbyte};
      3'b101:  load_val = {16'h0, rhalf};
      default: load_val = rword;
    endcase
  end

  // The head entry is still in place during the response cycle, so the CDB
  // fields are read from it directly and forced to 0 outside a completion.
  assign cdb_is_store = cdb_valid && h_is_store;
  assign cdb_rob      = cdb_valid ? h_rob : '0;
  assign cdb_rd_paddr = cdb_valid ? h_rd : '0;
  assign cdb_data     = (cdb_valid && !h_is_store) ? load_val : 32'h0;

endmodule

// File: tb/tb_lsq_inorder.sv
// tb/tb_lsq_inorder.sv - directed vector bench for lsq_inorder
module tb_lsq_inorder;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         enq_valid;
  logic         enq_ready;
  logic         enq_is_store;
  logic [2:0]   enq_funct3;
  logic [31:0]  enq_imm;
  logic [4:0]   enq_rob;
  logic [5:0]   enq_rd_paddr;
  logic [5:0]   enq_rs1_paddr;
  logic [5:0]   enq_rs2_paddr;
  logic [5:0]   rs1_paddr;
  logic [5:0]   rs2_paddr;
  logic [31:0]  p1_data;
  logic [31:0]  p2_data;
  logic         opnd_ready;
  logic [4:0]   rob_head;
  logic [31:0]  dmem_addr;
  logic [3:0]   dmem_rmask;
  logic [3:0]   dmem_wmask;
  logic [31:0]  dmem_wdata;
  logic         dmem_resp;
  logic [255:0] dmem_rdata;
  logic         cdb_valid;
  logic         cdb_is_store;
  logic [4:0]   cdb_rob;
  logic [5:0]   cdb_rd_paddr;
  logic [31:0]  cdb_data;
  logic [3:0]   count;

  lsq_inorder #(
    .DEPTH(8), .P_WIDTH(6), .ROB_WIDTH(5), .LINE_BITS(256)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_is_store(enq_is_store), .enq_funct3(enq_funct3), .enq_imm(enq_imm),
    .enq_rob(enq_rob), .enq_rd_paddr(enq_rd_paddr),
    .enq_rs1_paddr(enq_rs1_paddr), .enq_rs2_paddr(enq_rs2_paddr),
    .rs1_paddr(rs1_paddr), .rs2_paddr(rs2_paddr),
    .p1_data(p1_data), .p2_data(p2_data), .opnd_ready(opnd_ready),
    .rob_head(rob_head),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .cdb_valid(cdb_valid), .cdb_is_store(cdb_is_store), .cdb_rob(cdb_rob),
    .cdb_rd_paddr(cdb_rd_paddr), .cdb_data(cdb_data), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] e_addr;
    logic [3:0]  e_rmask;
    logic [3:0]  e_wmask;
    logic [31:0] e_wdata;
    int          wsel;
    logic [31:0] rword;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  task automatic set_enq(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                         input logic [4:0] rob, input logic [5:0] rd,
                         input logic [5:0] rs1, input logic [5:0] rs2);
    enq_is_store  = st;
    enq_funct3    = f3;
    enq_imm       = imm;
    enq_rob       = rob;
    enq_rd_paddr  = rd;
    enq_rs1_paddr = rs1;
    enq_rs2_paddr = rs2;
  endtask

  // Issue the current head load, answer it at once and check the CDB ROB index.
  task automatic run_head_load(input string name, input logic [4:0] exp_rob);
    opnd_ready = 1'b1;
    @(negedge clk);
    opnd_ready = 1'b0;
    #1;
    chk({name, " rmask"}, 32'(dmem_rmask), 32'hF);
    dmem_resp = 1'b1;
    #1;
    chk({name, " cdb_valid"}, 32'(cdb_valid), 32'd1);
    chk({name, " cdb_rob"}, 32'(cdb_rob), 32'(exp_rob));
    @(negedge clk);
    dmem_resp = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b0, 3'b000, 32'd3,        32'h1000, 32'h0,        32'h1000, 4'b1000, 4'b0000, 32'h0,        0, 32'h80FFFFFF, 32'hFFFFFF80};
    vt[1]  = '{1'b0, 3'b100, 32'd3,        32'h1000, 32'h0,        32'h1000, 4'b1000, 4'b0000, 32'h0,        0, 32'h80FFFFFF, 32'h00000080};
    vt[2]  = '{1'b0, 3'b010, 32'hC,        32'h10,   32'h0,        32'h1C,   4'b1111, 4'b0000, 32'h0,        7, 32'h71727374, 32'h71727374};
    vt[3]  = '{1'b0, 3'b001, 32'd2,        32'h4,    32'h0,        32'h4,    4'b1100, 4'b0000, 32'h0,        1, 32'h80017FFF, 32'hFFFF8001};
    vt[4]  = '{1'b0, 3'b101, 32'd8,        32'h20,   32'h0,        32'h28,   4'b0011, 4'b0000, 32'h0,        2, 32'h1234F00D, 32'h0000F00D};
    vt[5]  = '{1'b0, 3'b000, 32'hFFFFFFFF, 32'h100,  32'h0,        32'hFC,   4'b1000, 4'b0000, 32'h0,        7, 32'h7F000000, 32'h0000007F};
    vt[6]  = '{1'b1, 3'b010, 32'd4,        32'h40,   32'hCAFEBABE, 32'h44,   4'b0000, 4'b1111, 32'hCAFEBABE, 0, 32'h0,        32'h0};
    vt[7]  = '{1'b1, 3'b000, 32'd1,        32'h40,   32'h123456AB, 32'h40,   4'b0000, 4'b0010, 32'h0000AB00, 0, 32'h0,        32'h0};
    vt[8]  = '{1'b1, 3'b001, 32'd2,        32'h20,   32'h0000ABCD, 32'h20,   4'b0000, 4'b1100, 32'hABCD0000, 0, 32'h0,        32'h0};
    vt[9]  = '{1'b0, 3'b010, 32'd3,        32'h0,    32'h0,        32'h0,    4'b1000, 4'b0000, 32'h0,        0, 32'h5555AAAA, 32'h5555AAAA};
    vt[10] = '{1'b1, 3'b001, 32'd3,        32'h10,   32'h0000BEEF, 32'h10,   4'b0000, 4'b1000, 32'hBEEF0000, 0, 32'h0,        32'h0};
    vt[11] = '{1'b0, 3'b001, 32'd0,        32'h8,    32'h0,        32'h8,    4'b0011, 4'b0000, 32'h0,        2, 32'h12349ABC, 32'hFFFF9ABC};

    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0;
    set_enq(1'b0, 3'b000, 32'h0, 5'd0, 6'd0, 6'd0, 6'd0);
    p1_data = '0; p2_data = '0; opnd_ready = 1'b0; rob_head = '0;
    dmem_resp = 1'b0; dmem_rdata = '0;

    // ---------------- reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst count", 32'(count), 32'd0);
    chk("rst enq_ready", 32'(enq_ready), 32'd1);
    chk("rst dmem_addr", dmem_addr, 32'h0);
    chk("rst rmask", 32'(dmem_rmask), 32'h0);
    chk("rst wmask", 32'(dmem_wmask), 32'h0);
    chk("rst wdata", dmem_wdata, 32'h0);
    chk("rst cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst rs1_paddr", 32'(rs1_paddr), 32'd0);
    dmem_resp = 1'b1;
    #1;
    chk("stray resp cdb_valid", 32'(cdb_valid), 32'd0);
    @(negedge clk);
    dmem_resp = 1'b0;

    // ---------------- single-op vectors
    for (int i = 0; i < NV; i++) begin
      set_enq(vt[i].is_store, vt[i].f3, vt[i].imm, 5'(i + 1), 6'(i + 10), 6'(i + 20), 6'(i + 40));
      enq_valid = 1'b1;
      opnd_ready = 1'b0;
      @(negedge clk);
      enq_valid = 1'b0;
      #1;
      chk($sformatf("v%0d rs1_paddr", i), 32'(rs1_paddr), 32'(i + 20));
      chk($sformatf("v%0d rs2_paddr", i), 32'(rs2_paddr), 32'(i + 40));
      p1_data = vt[i].p1;
      p2_data = vt[i].p2;
      rob_head = 5'(i + 1);
      opnd_ready = 1'b1;
      @(negedge clk);
      opnd_ready = 1'b0;
      p1_data = 32'hFFFF0000;
      #1;
      chk($sformatf("v%0d addr", i), dmem_addr, vt[i].e_addr);
      chk($sformatf("v%0d rmask", i), 32'(dmem_rmask), 32'(vt[i].e_rmask));
      chk($sformatf("v%0d wmask", i), 32'(dmem_wmask), 32'(vt[i].e_wmask));
      chk($sformatf("v%0d wdata", i), dmem_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d no cdb before resp", i), 32'(cdb_valid), 32'd0);
      for (int w = 0; w < 8; w++)
        dmem_rdata[w*32 +: 32] = (w == vt[i].wsel) ? vt[i].rword : (32'hDEAD0000 | 32'(w));
      dmem_resp = 1'b1;
      #1;
      chk($sformatf("v%0d cdb_valid", i), 32'(cdb_valid), 32'd1);
      chk($sformatf("v%0d cdb_data", i), cdb_data, vt[i].e_data);
      chk($sformatf("v%0d cdb_rob", i), 32'(cdb_rob), 32'(i + 1));
      chk($sformatf("v%0d cdb_rd", i), 32'(cdb_rd_paddr), 32'(i + 10));
      chk($sformatf("v%0d cdb_is_store", i), 32'(cdb_is_store), 32'(vt[i].is_store));
      @(negedge clk);
      dmem_resp = 1'b0;
      #1;
      chk($sformatf("v%0d count after", i), 32'(count), 32'd0);
      chk($sformatf("v%0d masks cleared", i), 32'({dmem_rmask, dmem_wmask}), 32'h0);
    end

    // ---------------- store waits for the ROB head
    set_enq(1'b1, 3'b001, 32'd2, 5'd4, 6'd3, 6'd5, 6'd6);
    enq_valid = 1'b1;
    @(negedge clk);
    enq_valid = 1'b0;
    p1_data = 32'h20; p2_data = 32'h0000ABCD; rob_head = 5'd3; opnd_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("st wait%0d wmask", c), 32'(dmem_wmask), 32'h0);
    end
    rob_head = 5'd4;
    @(negedge clk);
    opnd_ready = 1'b0;
    #1;
    chk("st wmask", 32'(dmem_wmask), 32'hC);
    chk("st wdata", dmem_wdata, 32'hABCD0000);
    chk("st addr", dmem_addr, 32'h20);
    @(negedge clk);
    #1;
    chk("st held addr", dmem_addr, 32'h20);
    chk("st held wmask", 32'(dmem_wmask), 32'hC);
    chk("st no cdb w/o resp", 32'(cdb_valid), 32'd0);
    dmem_resp = 1'b1;
    #1;
    chk("st cdb_valid", 32'(cdb_valid), 32'd1);
    chk("st cdb_is_store", 32'(cdb_is_store), 32'd1);
    chk("st cdb_data", cdb_data, 32'h0);
    @(negedge clk);
    dmem_resp = 1'b0;

    // ---------------- full queue
    p1_data = 32'h100; dmem_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      set_enq(1'b0, 3'b010, 32'h0, 5'(i), 6'(i + 1), 6'd1, 6'd2);
      enq_valid = 1'b1;
      @(negedge clk);
    end
    #1;
    chk("full count", 32'(count), 32'd8);
    chk("full enq_ready", 32'(enq_ready), 32'd0);
    set_enq(1'b0, 3'b010, 32'h0, 5'd20, 6'd20, 6'd1, 6'd2);
    @(negedge clk);
    #1;
    chk("full 9th ignored", 32'(count), 32'd8);
    opnd_ready = 1'b1;
    @(negedge clk);
    opnd_ready = 1'b0;
    dmem_resp = 1'b1;
    #1;
    chk("full deq cdb_rob", 32'(cdb_rob), 32'd0);
    chk("full deq enq_ready", 32'(enq_ready), 32'd0);
    @(negedge clk);
    dmem_resp = 1'b0;
    enq_valid = 1'b0;
    #1;
    chk("full deq+enq count", 32'(count), 32'd7);
    for (int k = 1; k < 8; k++) run_head_load($sformatf("full drain%0d", k), 5'(k));
    #1;
    chk("full drained count", 32'(count), 32'd0);

    // ---------------- flush while a load is outstanding
    set_enq(1'b0, 3'b010, 32'h0, 5'd5, 6'd7, 6'd1, 6'd2);
    enq_valid = 1'b1;
    @(negedge clk);
    set_enq(1'b0, 3'b010, 32'h0, 5'd6, 6'd8, 6'd1, 6'd2);
    @(negedge clk);
    enq_valid = 1'b0;
    p1_data = 32'h200; opnd_ready = 1'b1;
    @(negedge clk);
    opnd_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush count", 32'(count), 32'd0);
    chk("flush rs1_paddr", 32'(rs1_paddr), 32'd0);
    chk("flush held rmask", 32'(dmem_rmask), 32'hF);
    set_enq(1'b0, 3'b010, 32'h0, 5'd9, 6'd9, 6'd3, 6'd4);
    enq_valid = 1'b1;
    p1_data = 32'h300; opnd_ready = 1'b1;
    @(negedge clk);
    enq_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("drain held addr", dmem_addr, 32'h200);
    dmem_resp = 1'b1;
    #1;
    chk("drain resp discarded", 32'(cdb_valid), 32'd0);
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    chk("drain rmask cleared", 32'(dmem_rmask), 32'h0);
    chk("drain count", 32'(count), 32'd1);
    @(negedge clk);
    opnd_ready = 1'b0;
    #1;
    chk("post-drain addr", dmem_addr, 32'h300);
    dmem_resp = 1'b1;
    #1;
    chk("post-drain cdb_rob", 32'(cdb_rob), 32'd9);
    @(negedge clk);
    dmem_resp = 1'b0;

    // ---------------- 20 back-to-back loads through the ring
    begin
      int enq_cnt = 0;
      int cmp_cnt = 0;
      int max_cnt = 0;
      int cyc = 0;
      logic acc;
      p1_data = 32'h100;
      opnd_ready = 1'b1;
      while (cmp_cnt < 20 && cyc < 400) begin
        @(negedge clk);
        #1;
        cyc++;
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (enq_cnt < 20) begin
          set_enq(1'b0, 3'b010, 32'h0, 5'(enq_cnt), 6'(enq_cnt + 1), 6'd1, 6'd2);
          enq_valid = 1'b1;
        end else begin
          enq_valid = 1'b0;
        end
        acc = enq_valid && enq_ready;
        dmem_resp = (dmem_rmask != 4'b0000);
        dmem_rdata = {224'h0, 32'h1000 + 32'(cmp_cnt)};
        #1;
        if (!dmem_resp) chk("wrap cdb w/o resp", 32'(cdb_valid), 32'd0);
        if (cdb_valid) begin
          chk($sformatf("wrap%0d cdb_rob", cmp_cnt), 32'(cdb_rob), 32'(cmp_cnt % 32));
          chk($sformatf("wrap%0d cdb_data", cmp_cnt), cdb_data, 32'h1000 + 32'(cmp_cnt));
          cmp_cnt++;
        end
        if (acc) enq_cnt++;
      end
      @(negedge clk);
      enq_valid = 1'b0;
      dmem_resp = 1'b0;
      opnd_ready = 1'b0;
      #1;
      chk("wrap completions", 32'(cmp_cnt), 32'd20);
      chk("wrap max count", 32'(max_cnt), 32'd8);
      chk("wrap final count", 32'(count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
